// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I controller.
// Branch funct3 constants beyond beq are only consumed when MULTICYCLE_CTRL_BRANCH_EXT_EN is set.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecuteR,
        StExecuteI,
        StAluWb,
        StBranch,
        StJal,
        StTrap
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } alu_op_e;

    localparam logic [2:0] AluCtrlAdd = 3'd0;
    localparam logic [2:0] AluCtrlSub = 3'd1;
    localparam logic [2:0] AluCtrlAnd = 3'd2;
    localparam logic [2:0] AluCtrlOr  = 3'd3;
    localparam logic [2:0] AluCtrlSlt = 3'd5;

    localparam logic [2:0] ImmI = 3'd0;
    localparam logic [2:0] ImmS = 3'd1;
    localparam logic [2:0] ImmB = 3'd2;
    localparam logic [2:0] ImmJ = 3'd3;

    localparam logic [2:0] F3Beq  = 3'b000;
    localparam logic [2:0] F3Bne  = 3'b001;
    localparam logic [2:0] F3Blt  = 3'b100;
    localparam logic [2:0] F3Bge  = 3'b101;
    localparam logic [2:0] F3Bltu = 3'b110;
    localparam logic [2:0] F3Bgeu = 3'b111;

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OpStore:  return ImmS;
            OpBranch: return ImmB;
            OpJal:    return ImmJ;
            default:  return ImmI;
        endcase
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps ALUOp plus IR fields to an ALUControl code.
module mc_aludec
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 3
) (
    input  alu_op_e               alu_op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  op5,
    output logic [ALU_CTRL_W-1:0] alu_control
);

    always_comb begin
        alu_control = ALU_CTRL_W'(AluCtrlAdd);
        case (alu_op)
            AluOpSub: alu_control = ALU_CTRL_W'(AluCtrlSub);
            AluOpFunct: begin
                case (funct3)
                    // Only R-type can subtract; I-type funct7b5 is immediate bits.
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_CTRL_W'(AluCtrlSub)
                                                             : ALU_CTRL_W'(AluCtrlAdd);
                    3'b010:  alu_control = ALU_CTRL_W'(AluCtrlSlt);
                    3'b110:  alu_control = ALU_CTRL_W'(AluCtrlOr);
                    3'b111:  alu_control = ALU_CTRL_W'(AluCtrlAnd);
                    default: alu_control = ALU_CTRL_W'(AluCtrlAdd);
                endcase
            end
            default: alu_control = ALU_CTRL_W'(AluCtrlAdd);
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM with memory handshake, trap state and retire counter.
// Define MULTICYCLE_CTRL_BRANCH_EXT_EN to accept bne/blt/bge/bltu/bgeu besides beq.
module multicycle_controller
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W   = 3,
    parameter int unsigned IMM_SRC_W    = 3,
    parameter int unsigned RETIRE_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              op,
    input  logic [2:0]              funct3,
    input  logic                    funct7b5,
    input  logic                    Zero,
    input  logic                    Negative,
    input  logic                    Carry,
    input  logic                    Overflow,
    input  logic                    mem_ready,
    output logic                    PCWrite,
    output logic                    AdrSrc,
    output logic                    MemWrite,
    output logic                    IRWrite,
    output logic                    RegWrite,
    output logic [1:0]              ResultSrc,
    output logic [1:0]              ALUSrcA,
    output logic [1:0]              ALUSrcB,
    output logic [IMM_SRC_W-1:0]    ImmSrc,
    output logic [ALU_CTRL_W-1:0]   ALUControl,
    output logic                    illegal,
    output logic                    instr_done,
    output logic [RETIRE_CNT_W-1:0] retired_count
);

    state_e                  state_q, state_d;
    alu_op_e                 alu_op;
    logic                    retire;
    logic                    br_legal, br_taken;
    logic [RETIRE_CNT_W-1:0] retired_q;

    always_comb begin
        br_legal = 1'b0;
        br_taken = 1'b0;
        case (funct3)
            F3Beq:  begin br_legal = 1'b1; br_taken = Zero; end
`ifdef MULTICYCLE_CTRL_BRANCH_EXT_EN
            F3Bne:  begin br_legal = 1'b1; br_taken = !Zero; end
            F3Blt:  begin br_legal = 1'b1; br_taken = Negative ^ Overflow; end
            F3Bge:  begin br_legal = 1'b1; br_taken = !(Negative ^ Overflow); end
            F3Bltu: begin br_legal = 1'b1; br_taken = !Carry; end
            F3Bgeu: begin br_legal = 1'b1; br_taken = Carry; end
`endif
            default: begin br_legal = 1'b0; br_taken = 1'b0; end
        endcase
    end

`ifndef MULTICYCLE_CTRL_BRANCH_EXT_EN
    logic unused_flags;
    assign unused_flags = ^{Negative, Carry, Overflow};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + RETIRE_CNT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = AluOpAdd;
        illegal   = 1'b0;
        retire    = 1'b0;
        unique case (state_q)
            StFetch: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecuteR;
                    OpIType:         state_d = StExecuteI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    default:         state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StMemWrite: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StExecuteR: begin
                ALUSrcA = 2'b10;
                alu_op  = AluOpFunct;
                state_d = StAluWb;
            end
            StExecuteI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = AluOpFunct;
                state_d = StAluWb;
            end
            StAluWb: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            StBranch: begin
                ALUSrcA = 2'b10;
                alu_op  = AluOpSub;
                if (br_legal) begin
                    PCWrite = br_taken;
                    retire  = 1'b1;
                    state_d = StFetch;
                end else begin
                    state_d = StTrap;
                end
            end
            StJal: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = StAluWb;
            end
            StTrap: begin
                illegal = 1'b1;
            end
            default: state_d = StFetch;
        endcase
        // Reset squashes every side effect of the instruction in flight.
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
            retire   = 1'b0;
        end
    end

    mc_aludec #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_aludec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );

    assign ImmSrc        = IMM_SRC_W'(imm_src_of(op));
    assign instr_done    = retire;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus a randomized
// instruction stream checked against per-instruction expected cycle timelines.
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, funct7b5, Zero, Negative, Carry, Overflow, mem_ready;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal, instr_done;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0]  ImmSrc, ALUControl;
    logic [31:0] retired_count;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_count = '0;

    // f = {mem_ready to drive, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, instr_done}
    typedef struct packed {
        logic [6:0] f;
        logic [2:0] alu;
    } cyc_t;
    cyc_t q[$];

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal),
        .instr_done(instr_done), .retired_count(retired_count)
    );

    function automatic logic rb();
        return $urandom_range(0, 1) != 0;
    endfunction

    function automatic cyc_t mk(input logic [6:0] f, input logic [2:0] alu);
        cyc_t c;
        c.f = f;
        c.alu = alu;
        return c;
    endfunction

    function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic sub_ok);
        if (f3 == 3'b000) return sub_ok ? 3'd1 : 3'd0;
        if (f3 == 3'b010) return 3'd5;
        if (f3 == 3'b110) return 3'd3;
        if (f3 == 3'b111) return 3'd2;
        return 3'd0;
    endfunction

    function automatic logic [2:0] ref_imm(input logic [6:0] o);
        if (o == OP_SW) return 3'd1;
        if (o == OP_BR) return 3'd2;
        if (o == OP_JAL) return 3'd3;
        return 3'd0;
    endfunction

    task automatic ref_branch(input logic [2:0] f3, input logic z, n, c, v,
                              output logic legal, output logic taken);
        legal = 1'b0;
        taken = 1'b0;
        if (f3 == 3'b000) begin legal = 1'b1; taken = z; end
`ifdef MULTICYCLE_CTRL_BRANCH_EXT_EN
        else if (f3 == 3'b001) begin legal = 1'b1; taken = !z; end
        else if (f3 == 3'b100) begin legal = 1'b1; taken = n ^ v; end
        else if (f3 == 3'b101) begin legal = 1'b1; taken = !(n ^ v); end
        else if (f3 == 3'b110) begin legal = 1'b1; taken = !c; end
        else if (f3 == 3'b111) begin legal = 1'b1; taken = c; end
`endif
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o;
        funct3 = f3;
        funct7b5 = f7;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_instr(OP_R, 3'b000, 1'b0);
        mem_ready = 1'b1;
        #1;
        n_checks++; if ({PCWrite, IRWrite, MemWrite, RegWrite, illegal, instr_done} !== 6'b0)
            $display("FAIL reset_enables got=%b exp=000000",
                     {PCWrite, IRWrite, MemWrite, RegWrite, illegal, instr_done});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (IRWrite !== 1'b1) $display("FAIL reset_fetch_irwrite got=%b exp=1", IRWrite);
        else n_pass++;
        n_checks++; if ({ALUSrcB, ResultSrc, AdrSrc} !== 5'b10100)
            $display("FAIL reset_fetch_selects got=%b exp=10100", {ALUSrcB, ResultSrc, AdrSrc});
        else n_pass++;
        n_checks++; if (retired_count !== 32'd0)
            $display("FAIL reset_count got=%0d exp=0", retired_count);
        else n_pass++;
        mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        set_instr(OP_R, 3'b000, 1'b0);
        mem_ready = 1'b1;
        #1;
        n_checks++; if ({IRWrite, PCWrite} !== 2'b11)
            $display("FAIL add_fetch got=%b exp=11", {IRWrite, PCWrite});
        else n_pass++;
        @(negedge clk); #1;
        n_checks++; if ({ALUSrcA, ALUSrcB, RegWrite} !== 5'b01010)
            $display("FAIL add_decode got=%b exp=01010", {ALUSrcA, ALUSrcB, RegWrite});
        else n_pass++;
        @(negedge clk); #1;
        n_checks++; if ({ALUControl, ALUSrcA, RegWrite, instr_done} !== 7'b0001000)
            $display("FAIL add_execute got=%b exp=0001000",
                     {ALUControl, ALUSrcA, RegWrite, instr_done});
        else n_pass++;
        @(negedge clk); #1;
        n_checks++; if ({RegWrite, instr_done, ResultSrc} !== 4'b1100)
            $display("FAIL add_aluwb got=%b exp=1100", {RegWrite, instr_done, ResultSrc});
        else n_pass++;
        @(negedge clk);
        exp_count++;
        mem_ready = 1'b0;
        #1;
        n_checks++; if ({retired_count, instr_done} !== {exp_count, 1'b0})
            $display("FAIL add_count got=%0d/%b exp=%0d/0", retired_count, instr_done, exp_count);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_lw_stall();
        set_instr(OP_LW, 3'b010, 1'b0);
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        n_checks++; if ({ALUSrcA, ALUSrcB, ImmSrc} !== 7'b1001000)
            $display("FAIL lw_memadr got=%b exp=1001000", {ALUSrcA, ALUSrcB, ImmSrc});
        else n_pass++;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k == 3);
            #1;
            n_checks++; if ({AdrSrc, RegWrite, instr_done} !== 3'b100)
                $display("FAIL lw_memread%0d got=%b exp=100", k, {AdrSrc, RegWrite, instr_done});
            else n_pass++;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        n_checks++; if ({RegWrite, ResultSrc, instr_done} !== 4'b1011)
            $display("FAIL lw_memwb got=%b exp=1011", {RegWrite, ResultSrc, instr_done});
        else n_pass++;
        @(negedge clk);
        exp_count++;
        #1;
        n_checks++; if (retired_count !== exp_count)
            $display("FAIL lw_count got=%0d exp=%0d", retired_count, exp_count);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            set_instr(OP_BR, 3'b000, 1'b0);
            Zero = (z == 1);
            mem_ready = 1'b1;
            @(negedge clk);
            @(negedge clk); #1;
            n_checks++; if ({PCWrite, instr_done, ALUControl} !== {Zero, 1'b1, SUB})
                $display("FAIL beq_z%0d got=%b exp=%b", z, {PCWrite, instr_done, ALUControl},
                         {Zero, 1'b1, SUB});
            else n_pass++;
            @(negedge clk);
            exp_count++;
            mem_ready = 1'b0;
            #1;
            n_checks++; if (retired_count !== exp_count)
                $display("FAIL beq_count_z%0d got=%0d exp=%0d", z, retired_count, exp_count);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int cls, sf, sm;
            logic [6:0] o;
            logic [2:0] f3;
            logic f7, z, n, c, v, legal, taken;
            cls = $urandom_range(0, 5);
            f3 = 3'($urandom_range(0, 7));
            f7 = rb(); z = rb(); n = rb(); c = rb(); v = rb();
            sf = $urandom_range(0, 2);
            sm = $urandom_range(0, 3);
            legal = 1'b0;
            taken = 1'b0;
            case (cls)
                0: o = OP_LW;
                1: o = OP_SW;
                2: o = OP_R;
                3: o = OP_I;
                4: begin
                    o = OP_BR;
                    ref_branch(f3, z, n, c, v, legal, taken);
                    while (!legal) begin
                        f3 = 3'($urandom_range(0, 7));
                        ref_branch(f3, z, n, c, v, legal, taken);
                    end
                end
                default: o = OP_JAL;
            endcase
            q.delete();
            for (int k = 0; k < sf; k++) q.push_back(mk(7'b0000000, ADD));
            q.push_back(mk(7'b1110000, ADD));
            q.push_back(mk({rb(), 6'b000000}, ADD));
            case (cls)
                0: begin
                    q.push_back(mk({rb(), 6'b000000}, ADD));
                    for (int k = 0; k < sm; k++) q.push_back(mk(7'b0000010, ADD));
                    q.push_back(mk(7'b1000010, ADD));
                    q.push_back(mk({rb(), 6'b000101}, ADD));
                end
                1: begin
                    q.push_back(mk({rb(), 6'b000000}, ADD));
                    for (int k = 0; k < sm; k++) q.push_back(mk(7'b0001010, ADD));
                    q.push_back(mk(7'b1001011, ADD));
                end
                2, 3: begin
                    q.push_back(mk({rb(), 6'b000000}, ref_alu(f3, o[5] & f7)));
                    q.push_back(mk({rb(), 6'b000101}, ADD));
                end
                4: q.push_back(mk({rb(), taken, 5'b00001}, SUB));
                default: begin
                    q.push_back(mk({rb(), 6'b100000}, ADD));
                    q.push_back(mk({rb(), 6'b000101}, ADD));
                end
            endcase
            set_instr(o, f3, f7);
            Zero = z; Negative = n; Carry = c; Overflow = v;
            for (int j = 0; j < q.size(); j++) begin
                mem_ready = q[j].f[6];
                #1;
                if (j == 0) begin
                    n_checks++; if ({retired_count, ImmSrc} !== {exp_count, ref_imm(o)})
                        $display("FAIL rnd%0d_count_imm got=%0d/%0d exp=%0d/%0d", i,
                                 retired_count, ImmSrc, exp_count, ref_imm(o));
                    else n_pass++;
                end
                n_checks++;
                if ({PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, instr_done, illegal, ALUControl}
                    !== {q[j].f[5:0], 1'b0, q[j].alu})
                    $display("FAIL rnd%0d_op%b_cyc%0d got=%b exp=%b", i, o, j,
                             {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, instr_done, illegal,
                              ALUControl}, {q[j].f[5:0], 1'b0, q[j].alu});
                else n_pass++;
                @(negedge clk);
            end
            exp_count++;
        end
        mem_ready = 1'b0;
        #1;
        n_checks++; if (retired_count !== exp_count)
            $display("FAIL rnd_final_count got=%0d exp=%0d", retired_count, exp_count);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        set_instr(OP_SW, 3'b010, 1'b0);
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_checks++; if (MemWrite !== 1'b1) $display("FAIL midrst_memwrite got=%b exp=1", MemWrite);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++; if ({MemWrite, instr_done, PCWrite} !== 3'b000)
            $display("FAIL midrst_squash got=%b exp=000", {MemWrite, instr_done, PCWrite});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        exp_count = '0;
        #1;
        n_checks++; if ({retired_count, ResultSrc, AdrSrc, MemWrite} !== {32'd0, 4'b1000})
            $display("FAIL midrst_fetch got=%0d/%b exp=0/1000", retired_count,
                     {ResultSrc, AdrSrc, MemWrite});
        else n_pass++;
        mem_ready = 1'b1;
        #1;
        n_checks++; if (IRWrite !== 1'b1) $display("FAIL midrst_irwrite got=%b exp=1", IRWrite);
        else n_pass++;
        mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_trap();
        set_instr(OP_BAD, 3'b000, 1'b0);
        mem_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++; if ({illegal, ImmSrc} !== 4'b0000)
            $display("FAIL trap_decode got=%b exp=0000", {illegal, ImmSrc});
        else n_pass++;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            mem_ready = rb();
            Zero = rb();
            #1;
            n_checks++;
            if ({illegal, PCWrite, IRWrite, MemWrite, RegWrite, instr_done} !== 6'b100000)
                $display("FAIL trap_hold%0d got=%b exp=100000", k,
                         {illegal, PCWrite, IRWrite, MemWrite, RegWrite, instr_done});
            else n_pass++;
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        n_checks++; if (illegal !== 1'b0) $display("FAIL trap_reset got=%b exp=0", illegal);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        exp_count = '0;
        mem_ready = 1'b0;
        #1;
        n_checks++; if ({illegal, retired_count} !== 33'd0)
            $display("FAIL trap_after got=%b/%0d exp=0/0", illegal, retired_count);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_branch_ext();
        set_instr(OP_BR, 3'b110, 1'b0);
        Zero = 1'b0; Carry = 1'b0; Negative = 1'b0; Overflow = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
`ifdef MULTICYCLE_CTRL_BRANCH_EXT_EN
        n_checks++; if ({PCWrite, instr_done, illegal} !== 3'b110)
            $display("FAIL bltu_taken got=%b exp=110", {PCWrite, instr_done, illegal});
        else n_pass++;
        @(negedge clk);
        exp_count++;
        mem_ready = 1'b0;
        #1;
        n_checks++; if (retired_count !== exp_count)
            $display("FAIL bltu_count got=%0d exp=%0d", retired_count, exp_count);
        else n_pass++;
        @(negedge clk);
`else
        n_checks++; if ({PCWrite, instr_done, illegal} !== 3'b000)
            $display("FAIL bltu_branch got=%b exp=000", {PCWrite, instr_done, illegal});
        else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (illegal !== 1'b1) $display("FAIL bltu_trap got=%b exp=1", illegal);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_count = '0;
        mem_ready = 1'b0;
        #1;
        n_checks++; if ({illegal, retired_count} !== 33'd0)
            $display("FAIL bltu_after got=%b/%0d exp=0/0", illegal, retired_count);
        else n_pass++;
        @(negedge clk);
`endif
    endtask

    initial begin
        reset = 1'b1;
        set_instr(OP_R, 3'b000, 1'b0);
        Zero = 1'b0; Negative = 1'b0; Carry = 1'b0; Overflow = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_add();
        test_lw_stall();
        test_beq();
        test_random();
        test_mid_reset();
        test_trap();
        test_branch_ext();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
